instr_fetch_unit: RTL and testbench

- Multi-cycle instruction fetch stage. It is the producer side of the opcode interface: it drives Op and the instruction fields into the main control decoder.
- Holds the PC and the instruction register (IR). Fetches from instruction memory over a valid/ready request channel plus a response channel.
- Presents one instruction at a time to execute, with a valid/accept handshake.
- Computes next PC from the decoder's branch/jump outputs and the ALU zero flag.

---
 rtl/instr_fetch_unit_pkg.sv | 29 ++
 rtl/instr_fetch_unit_next_pc.sv | 28 ++
 rtl/instr_fetch_unit.sv | 85 ++++++++
 tb/tb_instr_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, opcodes
// and instruction field positions.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Instruction field slice positions.
  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int INDEX_MSB  = 25;  // jump target index, [25:0]
  localparam int IMM_MSB    = 15;  // branch immediate, [15:0]

  // Branch displacement: sign-extended word offset turned into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [IMM_MSB:0] imm);
    return {{14{imm[IMM_MSB]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC selection from the decoder's jump/branch controls
// and the ALU zero flag. Jump wins over a taken branch.
module next_pc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0]        pc,
  input  logic [INDEX_MSB:0] index,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  output logic [31:0]        next_pc,
  output logic [31:0]        pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

  // Select the successor address; jump has priority over a taken branch.
  always_comb begin
    // NOTE: next_pc gets a default before any branching so no path can leave it unassigned (no latch).
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], index, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset(index[IMM_MSB:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: requests a word at pc, captures it into the IR,
// holds it for execute until accepted, then advances pc.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetN,
  output logic             imReqValid,
  input  logic             imReqReady,
  output logic [31:0]      imAddr,
  input  logic             imRespValid,
  input  logic [31:0]      imRespData,
  output logic [31:0]      instr,
  output logic [5:0]       Op,
  output logic             instrValid,
  input  logic             instrAccept,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  output logic [31:0]      pc,
  output logic [31:0]      pcPlus4,
  output logic [CNT_W-1:0] fetchCount
);

  fetch_state_e     state;
  logic [31:0]      pc_q;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      next_pc;

  next_pc_calc u_next_pc (
    .pc       (pc_q),
    .index    (ir_q[INDEX_MSB:0]),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .next_pc  (next_pc),
    .pc_plus4 (pcPlus4)
  );

  // Fetch FSM: request, wait for the response, hold IR until execute accepts.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= REQ;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      count_q <= '0;
    end else begin
      case (state)
        REQ: begin
          if (imReqReady) state <= WAIT;
        end
        WAIT: begin
          if (imRespValid) begin
            ir_q  <= imRespData;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (instrAccept) begin
            pc_q    <= next_pc;
            count_q <= count_q + CNT_W'(1);
            state   <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  // Reset parks the FSM in REQ, so the request is gated off while reset is
  // held; the first edge after release can then be accepted immediately.
  assign imReqValid = resetN && (state == REQ);
  assign imAddr     = pc_q;
  assign instrValid = (state == HOLD);
  assign instr      = ir_q;
  assign Op         = ir_q[OP_MSB:OP_LSB];
  assign pc         = pc_q;
  assign fetchCount = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver plays instruction memory
// and execute, pushing expected requests/instructions into queues; a monitor
// compares them whenever the DUT presents a request or a held instruction.
module tb_instr_fetch_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             resetN;
  logic             imReqValid;
  logic             imReqReady;
  logic [31:0]      imAddr;
  logic             imRespValid;
  logic [31:0]      imRespData;
  logic [31:0]      instr;
  logic [5:0]       Op;
  logic             instrValid;
  logic             instrAccept;
  logic             branch;
  logic             zero;
  logic             jump;
  logic [31:0]      pc;
  logic [31:0]      pcPlus4;
  logic [CNT_W-1:0] fetchCount;

  instr_fetch_unit #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .imReqValid  (imReqValid),
    .imReqReady  (imReqReady),
    .imAddr      (imAddr),
    .imRespValid (imRespValid),
    .imRespData  (imRespData),
    .instr       (instr),
    .Op          (Op),
    .instrValid  (instrValid),
    .instrAccept (instrAccept),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .pc          (pc),
    .pcPlus4     (pcPlus4),
    .fetchCount  (fetchCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] addr;
    int          cnt;
  } hold_t;

  logic [31:0] req_q[$];
  hold_t       hold_q[$];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  int          m_count;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Architectural successor address from the ISA rules.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input bit b, input bit z, input bit j);
    logic [31:0] seq;
    int          disp;
    seq  = cur + 32'd4;
    disp = int'($signed(word[15:0])) * 4;
    if (j)          return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    else if (b && z) return seq + 32'(disp);
    else             return seq;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One instruction: stall the request, return a word, hold, then accept.
  task automatic do_fetch(input logic [31:0] word, input int stall, input int rdly,
                          input int hold, input bit b, input bit z, input bit j,
                          input bit noisy);
    imReqReady = 1'b0;
    repeat (stall) begin
      imRespValid = noisy ? 1'($urandom) : 1'b0;
      imRespData  = ~word;
      instrAccept = noisy ? 1'($urandom) : 1'b0;
      branch      = 1'($urandom);
      zero        = 1'($urandom);
      jump        = 1'($urandom);
      cycle();
    end
    imRespValid = 1'b0;
    imReqReady  = 1'b1;
    cycle();
    imReqReady  = 1'b0;
    instrAccept = 1'b0;
    repeat (rdly) cycle();
    imRespValid = 1'b1;
    imRespData  = word;
    hold_q.push_back('{ir: word, addr: m_pc, cnt: m_count});
    m_ir = word;
    cycle();
    imRespValid = 1'b0;
    repeat (hold) begin
      imRespValid = noisy ? 1'($urandom) : 1'b0;
      imRespData  = $urandom;
      cycle();
    end
    imRespValid = 1'b0;
    instrAccept = 1'b1;
    branch      = b;
    zero        = z;
    jump        = j;
    cycle();
    instrAccept = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    jump        = 1'b0;
    m_pc    = model_next(m_pc, word, b, z, j);
    m_count = (m_count + 1) % (1 << CNT_W);
    req_q.push_back(m_pc);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},        pc, 32'h0);
    check({tag, "_valid"},     instrValid, 1'b0);
    check({tag, "_req_valid"}, imReqValid, 1'b0);
    check({tag, "_count"},     32'(fetchCount), 32'h0);
    check({tag, "_instr"},     instr, 32'h0);
  endtask

  // Monitor: compares DUT outputs against the scoreboard on falling edges.
  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      check("valid_exclusive", 32'(imReqValid & instrValid), 32'h0);
      if (imReqValid) begin
        check("req_expected", 32'(req_q.size() != 0), 32'h1);
        if (req_q.size() != 0) begin
          check("im_addr", imAddr, req_q[0]);
          check("ir_stable_in_req", instr, m_ir);
          if (imReqReady) void'(req_q.pop_front());
        end
      end
      if (instrValid) begin
        check("instr_expected", 32'(hold_q.size() != 0), 32'h1);
        if (hold_q.size() != 0) begin
          check("instr",       instr, hold_q[0].ir);
          check("op",          32'(Op), 32'(hold_q[0].ir >> 26));
          check("pc",          pc, hold_q[0].addr);
          check("pc_plus4",    pcPlus4, hold_q[0].addr + 32'd4);
          check("fetch_count", 32'(fetchCount), 32'(hold_q[0].cnt));
          if (instrAccept) void'(hold_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [5:0]  ops [6];
    logic [31:0] w;
    ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};

    resetN = 1'b0; imReqReady = 1'b0; imRespValid = 1'b0; imRespData = '0;
    instrAccept = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    m_pc = 32'h0; m_ir = 32'h0; m_count = 0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    resetN = 1'b1;
    req_q.push_back(m_pc);
    @(posedge clk); #1;

    // Directed: sequential, jump with backpressure/hold, BEQ taken,
    // jump priority over branch, BEQ not taken.
    do_fetch(32'h2008_0005, 0, 0, 0,  1'b0, 1'b0, 1'b0, 1'b0);  // 0   -> 4
    do_fetch(32'h0800_0004, 5, 1, 10, 1'b0, 1'b0, 1'b1, 1'b1);  // 4   -> 0x10
    do_fetch(32'h1000_FFFE, 0, 0, 0,  1'b1, 1'b1, 1'b0, 1'b0);  // 0x10 -> 0x0C
    do_fetch(32'h0800_0004, 1, 0, 2,  1'b1, 1'b1, 1'b1, 1'b0);  // 0x0C -> 0x10
    do_fetch(32'h1000_FFFE, 0, 2, 0,  1'b1, 1'b0, 1'b0, 1'b0);  // 0x10 -> 0x14

    // Reset while waiting for a response; that response must be dropped.
    imReqReady = 1'b1;
    cycle();
    imReqReady = 1'b0;
    resetN = 1'b0;
    #1;
    check_reset_values("reset_mid_wait");
    void'(req_q.pop_front());
    check("req_q_after_reset", 32'(req_q.size()), 32'h0);
    req_q.delete();
    hold_q.delete();
    m_pc = 32'h0; m_ir = 32'h0; m_count = 0;
    imRespValid = 1'b1;
    imRespData  = 32'hDEAD_BEEF;
    cycle();
    resetN = 1'b1;
    imRespValid = 1'b0;
    req_q.push_back(m_pc);
    cycle();

    // pc wrap: branch back from 0 to 0xFFFF_FFFC, then fall through to 0.
    do_fetch(32'h1000_FFFE, 2, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    do_fetch(32'h2008_0005, 0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic; the 4-bit counter wraps several times.
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 5)];
      do_fetch(w, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
    end

    repeat (3) cycle();
    check("hold_q_drained", 32'(hold_q.size()), 32'h0);
    check("req_pending_at_end", 32'(req_q.size()), 32'h1);
    check("final_count", 32'(fetchCount), 32'(m_count));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
